// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage pipelined execute unit for register shift ops.
//   S1 (issue register) captures the decoded op and drives the sll/sra barrel
//   shifters; S2 (result register) holds the selected result and drives out_*.
//   Valid/ready handshakes on both sides give full backpressure, and a flush
//   discards everything in flight.
// Configuration macro:
//   SHIFT_SRL_EN - when defined, op 5'b00110 is a logical right shift derived
//                  from the sra shifter output with the vacated upper bits
//                  masked to zero. When undefined that op is unsupported.
module shift_exec_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [31:0] in_operand,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    // Decoded ALU op encodings handled by this unit.
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_SRL = 5'b00110;

    // Left barrel shifter: five binary-weighted stages, zero fill.
    function automatic logic [31:0] sll32(input logic [31:0] a, input logic [4:0] b);
        logic [31:0] t;
        t = a;
        t = b[0] ? {t[30:0], 1'b0}     : t;
        t = b[1] ? {t[29:0], 2'b00}    : t;
        t = b[2] ? {t[27:0], 4'h0}     : t;
        t = b[3] ? {t[23:0], 8'h00}    : t;
        t = b[4] ? {t[15:0], 16'h0000} : t;
        return t;
    endfunction

    // Arithmetic right barrel shifter: five stages, sign bit replicated.
    function automatic logic [31:0] sra32(input logic [31:0] a, input logic [4:0] b);
        logic        s;
        logic [31:0] t;
        s = a[31];
        t = a;
        t = b[0] ? {s, t[31:1]}          : t;
        t = b[1] ? {{2{s}}, t[31:2]}     : t;
        t = b[2] ? {{4{s}}, t[31:4]}     : t;
        t = b[3] ? {{8{s}}, t[31:8]}     : t;
        t = b[4] ? {{16{s}}, t[31:16]}   : t;
        return t;
    endfunction

    // Stage S1: issue register.
    logic        s1_valid_q,   s1_valid_d;
    logic [4:0]  s1_op_q,      s1_op_d;
    logic [31:0] s1_operand_q, s1_operand_d;
    logic [4:0]  s1_shamt_q,   s1_shamt_d;
    logic [4:0]  s1_rd_q,      s1_rd_d;

    // Stage S2: result register.
    logic        s2_valid_q,   s2_valid_d;
    logic [31:0] s2_result_q,  s2_result_d;
    logic [4:0]  s2_rd_q,      s2_rd_d;
    logic        s2_err_q,     s2_err_d;

    // Handshake / advance controls.
    logic        out_fire_s;
    logic        s2_load_s;
    logic        in_ready_s;
    logic        in_fire_s;

    // Shifter outputs and selected result.
    logic [31:0] sll_out_s;
    logic [31:0] sra_out_s;
    logic [31:0] sel_result_s;
    logic        sel_err_s;
`ifdef SHIFT_SRL_EN
    logic [31:0] srl_mask_s;
    logic [31:0] srl_out_s;
`endif

    // Transfer and advance conditions; in_ready looks through to out_ready so
    // a full pipe keeps accepting one op per cycle while the output drains.
    always_comb begin
        out_fire_s = s2_valid_q & out_ready;
        s2_load_s  = s1_valid_q & (~s2_valid_q | out_fire_s);
        in_ready_s = ~s1_valid_q | s2_load_s;
        in_fire_s  = in_valid & in_ready_s;
    end

    assign in_ready = in_ready_s;

    // Barrel shifters driven from the S1 fields.
    always_comb begin
        sll_out_s = sll32(s1_operand_q, s1_shamt_q);
        sra_out_s = sra32(s1_operand_q, s1_shamt_q);
    end

`ifdef SHIFT_SRL_EN
    // Logical right shift reuses the sra result: clear the top shamt bits,
    // which are exactly the positions the sign fill may have set.
    always_comb begin
        srl_mask_s = 32'hFFFF_FFFF >> s1_shamt_q;
        srl_out_s  = sra_out_s & srl_mask_s;
    end
`endif

    // Result select; anything unrecognised passes the operand through and
    // flags err so the op still retires in order.
    always_comb begin
        sel_result_s = s1_operand_q;
        sel_err_s    = 1'b1;
        case (s1_op_q)
            OP_SLL: begin
                sel_result_s = sll_out_s;
                sel_err_s    = 1'b0;
            end
            OP_SRA: begin
                sel_result_s = sra_out_s;
                sel_err_s    = 1'b0;
            end
`ifdef SHIFT_SRL_EN
            OP_SRL: begin
                sel_result_s = srl_out_s;
                sel_err_s    = 1'b0;
            end
`endif
            default: begin
                sel_result_s = s1_operand_q;
                sel_err_s    = 1'b1;
            end
        endcase
    end

    // S1 next state: flush wins, then accept new op, then empty on advance,
    // otherwise hold so a stalled op stays stable.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_operand_d = s1_operand_q;
        s1_shamt_d   = s1_shamt_q;
        s1_rd_d      = s1_rd_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_fire_s) begin
            s1_valid_d   = 1'b1;
            s1_op_d      = in_op;
            s1_operand_d = in_operand;
            s1_shamt_d   = in_shamt;
            s1_rd_d      = in_rd;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: flush wins, then take S1, then empty on drain,
    // otherwise hold the presented result.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_rd_d     = s2_rd_q;
        s2_err_d    = s2_err_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_load_s) begin
            s2_valid_d  = 1'b1;
            s2_result_d = sel_result_s;
            s2_rd_d     = s1_rd_q;
            s2_err_d    = sel_err_s;
        end else if (out_fire_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous active-low reset clearing everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 5'd0;
            s1_operand_q <= 32'd0;
            s1_shamt_q   <= 5'd0;
            s1_rd_q      <= 5'd0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'd0;
            s2_rd_q      <= 5'd0;
            s2_err_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_operand_q <= s1_operand_d;
            s1_shamt_q   <= s1_shamt_d;
            s1_rd_q      <= s1_rd_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_rd_q      <= s2_rd_d;
            s2_err_q     <= s2_err_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_rd     = s2_rd_q;
    assign out_err    = s2_err_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Testbench for shift_exec_stage: directed steps followed by random traffic,
// all checked against an in-order queue model of the pipe contents.
module tb_shift_exec_stage;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_operand;
    logic [4:0]  in_shamt;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_err;

    shift_exec_stage dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .in_shamt   (in_shamt),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_err    (out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [4:0] SLL = 5'b00100;
    localparam logic [4:0] SRA = 5'b00101;
    localparam logic [4:0] SRL = 5'b00110;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
        int          acc;
    } item_t;

    item_t q[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the op definitions.
    task automatic ref_calc(input logic [4:0] op, input logic [31:0] opd, input logic [4:0] sh,
                            output logic [31:0] res, output logic err);
        logic signed [31:0] sopd;
        sopd = opd;
        case (op)
            SLL: begin res = opd << sh; err = 1'b0; end
            SRA: begin res = sopd >>> sh; err = 1'b0; end
`ifdef SHIFT_SRL_EN
            SRL: begin res = opd >> sh; err = 1'b0; end
`endif
            default: begin res = opd; err = 1'b1; end
        endcase
    endtask

    // One clock cycle: drive inputs, check against the model before the edge,
    // update the model, then advance to just after the edge.
    task automatic step(input logic iv, input logic [4:0] op, input logic [31:0] opd,
                        input logic [4:0] sh, input logic [4:0] rd, input logic ordy,
                        input logic fl);
        logic  exp_ready;
        logic  exp_ov;
        item_t it;
        in_valid   = iv;
        in_op      = op;
        in_operand = opd;
        in_shamt   = sh;
        in_rd      = rd;
        out_ready  = ordy;
        flush      = fl;
        #2;
        exp_ready = (q.size() < 2) || ordy;
        exp_ov    = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            check("out_result", out_result, q[0].res);
            check("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            check("out_err", {31'd0, out_err}, {31'd0, q[0].err});
            if (ordy) void'(q.pop_front());
        end
        if (iv && exp_ready) begin
            ref_calc(op, opd, sh, it.res, it.err);
            it.rd  = rd;
            it.acc = cyc;
            q.push_back(it);
        end
        if (fl) q.delete();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clock);
        cyc++;
        #1;
        reset_n = 1'b1;
        q.delete();
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_srl;
        logic        exp_srl_err;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_op      = 5'd0;
        in_operand = 32'd0;
        in_shamt   = 5'd0;
        in_rd      = 5'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        @(posedge clock);
        cyc++;
        do_reset();

        // Basic latency: sra of the sign bit by 31.
        step(1'b1, SRA, 32'h8000_0000, 5'd31, 5'd7, 1'b1, 1'b0);
        idle(1'b1);
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_result", out_result, 32'hFFFF_FFFF);
        check("lat_rd", {27'd0, out_rd}, 32'd7);
        idle(1'b1);

        // sll to the top bit, then a zero-amount sra, back to back.
        step(1'b1, SLL, 32'h0000_0001, 5'd31, 5'd11, 1'b1, 1'b0);
        step(1'b1, SRA, 32'h1234_ABCD, 5'd0, 5'd12, 1'b1, 1'b0);
        check("sll31", out_result, 32'h8000_0000);
        idle(1'b1);
        check("sra0", out_result, 32'h1234_ABCD);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: three ops against a stalled output.
        step(1'b1, SLL, 32'h0000_0003, 5'd1, 5'd1, 1'b0, 1'b0);
        step(1'b1, SRA, 32'hF000_0000, 5'd2, 5'd2, 1'b0, 1'b0);
        step(1'b1, SLL, 32'h0000_00FF, 5'd8, 5'd3, 1'b0, 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_head_rd", {27'd0, out_rd}, 32'd1);
        step(1'b1, SLL, 32'h0000_00FF, 5'd8, 5'd3, 1'b0, 1'b0);
        idle(1'b0);
        check("bp_hold_rd", {27'd0, out_rd}, 32'd1);
        check("bp_hold_result", out_result, 32'h0000_0006);
        step(1'b1, SLL, 32'h0000_00FF, 5'd8, 5'd3, 1'b1, 1'b0);
        check("bp_second_rd", {27'd0, out_rd}, 32'd2);
        idle(1'b1);
        check("bp_third_rd", {27'd0, out_rd}, 32'd3);
        idle(1'b1);
        idle(1'b1);

        // Flush with a full pipe and a concurrent input.
        step(1'b1, SLL, 32'h0000_0010, 5'd1, 5'd4, 1'b0, 1'b0);
        step(1'b1, SLL, 32'h0000_0020, 5'd1, 5'd5, 1'b0, 1'b0);
        step(1'b1, SLL, 32'h0000_0040, 5'd1, 5'd6, 1'b0, 1'b1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Reset with two ops in flight, then a normal op.
        step(1'b1, SRA, 32'h8000_0001, 5'd3, 5'd8, 1'b0, 1'b0);
        step(1'b1, SRA, 32'h8000_0002, 5'd3, 5'd9, 1'b0, 1'b0);
        do_reset();
        step(1'b1, SLL, 32'h0000_00F0, 5'd4, 5'd10, 1'b1, 1'b0);
        idle(1'b1);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_result", out_result, 32'h0000_0F00);
        check("post_rst_rd", {27'd0, out_rd}, 32'd10);
        idle(1'b1);

        // Config-dependent srl and an unsupported op.
`ifdef SHIFT_SRL_EN
        exp_srl     = 32'h0800_0000;
        exp_srl_err = 1'b0;
`else
        exp_srl     = 32'h8000_0000;
        exp_srl_err = 1'b1;
`endif
        step(1'b1, SRL, 32'h8000_0000, 5'd4, 5'd13, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 32'h5A5A_5A5A, 5'd3, 5'd14, 1'b1, 1'b0);
        check("srl_result", out_result, exp_srl);
        check("srl_err", {31'd0, out_err}, {31'd0, exp_srl_err});
        idle(1'b1);
        check("bad_op_result", out_result, 32'h5A5A_5A5A);
        check("bad_op_err", {31'd0, out_err}, 32'd1);
        idle(1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rop;
            case ($urandom_range(0, 3))
                0:       rop = SLL;
                1:       rop = SRA;
                2:       rop = SRL;
                default: rop = 5'($urandom_range(0, 31));
            endcase
            step(1'($urandom_range(0, 3) != 0), rop, $urandom, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drain_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Two-stage pipelined execute unit for register shift instructions. It accepts a decoded shift op, a 32-bit operand, a 5-bit shift amount and a destination tag from the decode/issue stage. It drives the team's combinational sll/sra barrel shifters and presents a registered result to the memory/writeback stage. Valid/ready handshakes on both sides provide full backpressure without dropping or reordering operations.

## Interface
- No parameters; data width is fixed at 32 bits and shift amount at 5 bits.
- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage can accept an operation this cycle
- in_op  input  5  ALU op: 5'b00100 sll, 5'b00101 sra, 5'b00110 srl (config-dependent)
- in_operand  input  32  value to shift
- in_shamt  input  5  shift amount, 0..31
- in_rd  input  5  destination register tag, passed through
- flush  input  1  discard all in-flight operations
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_result  output  32  shifted value
- out_rd  output  5  destination tag of result
- out_err  output  1  op was not a supported shift

## Operation
- Stage S1 (issue register) holds op, operand, shamt, rd and a valid bit. The shifters are driven from S1 fields.
- Stage S2 (result register) holds the selected shifter output, rd, err and a valid bit. It drives out_* directly.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Advance rules:
  - S2 loads from S1 when S1 valid and (S2 empty or S2 transferring).
  - S1 loads from the input when it is empty or advancing this cycle.
- in_ready = !S1.valid || S1 advancing. It is combinational from out_ready, so a full pipe still accepts one op per cycle when the output drains.
- Result select:
  - sll: operand << shamt, zero fill.
  - sra: arithmetic right shift, bit 31 replicated.
  - srl: logical right shift, zero fill; only when enabled.
- Unsupported op: result = operand unchanged, err = 1. The op still occupies the pipe and must be handshaken out.
- shamt = 0: result equals operand for every op.
- Payload stability: while out_valid && !out_ready, out_result, out_rd and out_err hold stable. Same rule applies to S1 contents while S1 is stalled.
- Flush:
  - Clears both valid bits on the next edge.
  - An input handshake in the same cycle as flush is dropped.
  - Flush takes priority over all advances.
- Reset priority: reset_n low overrides flush and all handshakes.

## Timing
- Latency: result appears on out_valid 2 cycles after the input handshake edge, with no stalls.
- Throughput: 1 op/cycle sustained while out_ready stays high.
- Reset (reset_n low at an edge): S1/S2 valid = 0, all payload registers = 0. Resulting outputs:
  - out_valid = 0, out_result = 0, out_rd = 0, out_err = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation: in-flight ops are lost and no partial result is emitted.
- Backpressure: if out_ready stays low, at most 2 ops are held. in_ready goes low once both stages are valid.
- Simultaneous output drain and input accept with a full pipe: S2 takes S1, S1 takes the input, in the same edge.

## Configuration
- SHIFT_SRL_EN defined: op 5'b00110 performs a logical right shift, built from the sra shifter output with the upper shamt bits masked to zero. out_err = 0 for that op.
- SHIFT_SRL_EN undefined: 5'b00110 is unsupported, so result = operand and out_err = 1. No masking logic is synthesized.

## Test plan
- Basic latency: sra, operand 32'h80000000, shamt 31, out_ready=1 -> out_result 32'hFFFFFFFF, out_rd preserved, out_valid exactly 2 cycles after accept.
- sll/zero shift: sll 32'h00000001 shamt 31 -> 32'h80000000; sra 32'h1234ABCD shamt 0 -> 32'h1234ABCD.
- Backpressure:
  - Stimulus: out_ready=0, present 3 back-to-back ops with rd 1, 2, 3.
  - Required: in_ready drops after 2 accepts, outputs hold stable.
  - Then raise out_ready: results emerge in order 1, 2, 3 with no loss.
- Flush:
  - Stimulus: pipe full plus flush asserted together with in_valid.
  - Required: next cycle out_valid=0, in_ready=1, and no result from any of the three ops ever appears.
- Reset mid-stream: reset_n low for 1 cycle with 2 ops in flight -> all outputs 0 next cycle; a subsequent op completes normally with 2-cycle latency.
- Config and err:
  - With SHIFT_SRL_EN: op 5'b00110, 32'h80000000, shamt 4 -> 32'h08000000, err 0.
  - Without SHIFT_SRL_EN: same stimulus -> 32'h80000000, err 1.
  - Op 5'b00000 -> operand unchanged, err 1 in both builds.
